uart_trx: RTL and testbench

UART_TRX -- requirements
Module: uart_trx

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_trx.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_trx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transceiver: parity modes, FSM encodings and
// the parity-bit helper used by both directions.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_START = 3'd1;
  localparam logic [2:0] TX_DATA  = 3'd2;
  localparam logic [2:0] TX_PAR   = 3'd3;
  localparam logic [2:0] TX_STOP  = 3'd4;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_PAR       = 3'd3;
  localparam logic [2:0] RX_STOP      = 3'd4;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

  // Parity bit that makes data+parity odd (PAR_ODD) or even (otherwise).
  function automatic logic par_bit(input logic data_xor, input int mode);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counting bit timer. tick fires once the loaded period has elapsed;
// the owner reloads on tick to get a periodic strobe.
module uart_bit_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == 16'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val - 16'd1;
    end else if (en && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_trx.sv
// Full-duplex UART: independent transmitter and receiver sharing one clock,
// each paced by its own uart_bit_timer.
module uart_trx
  import uart_pkg::*;
#(
  parameter int BAUD_DIVIDER = 9,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  if (BAUD_DIVIDER < 4 || BAUD_DIVIDER > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_trx: illegal parameter value");
  end

  localparam logic [15:0] BIT_LEN  = 16'(BAUD_DIVIDER);
  localparam logic [15:0] HALF_LEN = 16'(BAUD_DIVIDER / 2);
  localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

  // ---------------- Transmitter ----------------
  logic [2:0]           tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic                 tx_stop_q, tx_stop_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_load, tx_tick;

  assign tx       = tx_q;
  assign tx_ready = (tx_state_q == TX_IDLE);

  uart_bit_timer u_tx_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tx_load),
    .load_val (BIT_LEN),
    .en       (tx_state_q != TX_IDLE),
    .tick     (tx_tick)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_par_d   = par_bit(^tx_data, PARITY);
          tx_d       = 1'b0;
          tx_load    = 1'b1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = 4'd0;
          tx_load    = 1'b1;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_load = 1'b1;
          if (tx_bit_q == LAST_BIT) begin
            if (PARITY != PAR_NONE) begin
              tx_d       = tx_par_q;
              tx_state_d = TX_PAR;
            end else begin
              tx_d       = 1'b1;
              tx_stop_d  = 1'b0;
              tx_state_d = TX_STOP;
            end
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end
      end
      TX_PAR: begin
        if (tx_tick) begin
          tx_d       = 1'b1;
          tx_stop_d  = 1'b0;
          tx_load    = 1'b1;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          if (tx_stop_q || (STOP_BITS == 1)) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_stop_d = 1'b1;
            tx_load   = 1'b1;
          end
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop_q  <= tx_stop_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  // ---------------- Receiver ----------------
  logic                 rx_meta_q, rx_sync_q;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic                 rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_load, rx_tick;
  logic [15:0]          rx_load_val;

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;

  uart_bit_timer u_rx_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rx_load),
    .load_val (rx_load_val),
    .en       ((rx_state_q != RX_IDLE) && (rx_state_q != RX_WAIT_HIGH)),
    .tick     (rx_tick)
  );

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_shift_d  = rx_shift_q;
    rx_bit_d    = rx_bit_q;
    rx_par_d    = rx_par_q;
    rx_data_d   = rx_data_q;
    rx_perr_d   = rx_perr_q;
    rx_ferr_d   = rx_ferr_q;
    rx_valid_d  = 1'b0;
    rx_load     = 1'b0;
    rx_load_val = BIT_LEN;
    case (rx_state_q)
      RX_IDLE: begin
        // First timer period lands mid-start-bit; later ones are full bits.
        if (!rx_sync_q) begin
          rx_load     = 1'b1;
          rx_load_val = HALF_LEN;
          rx_state_d  = RX_START;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_bit_d   = 4'd0;
            rx_load    = 1'b1;
            rx_state_d = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_load    = 1'b1;
          if (rx_bit_q == LAST_BIT) begin
            rx_state_d = (PARITY != PAR_NONE) ? RX_PAR : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end
      end
      RX_PAR: begin
        if (rx_tick) begin
          rx_par_d   = rx_sync_q;
          rx_load    = 1'b1;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shift_q;
          rx_ferr_d  = ~rx_sync_q;
          rx_perr_d  = (PARITY != PAR_NONE) && (par_bit(^rx_shift_q, PARITY) != rx_par_q);
          rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync_q) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

endmodule

// File: tb/tb_uart_trx.sv
// Scoreboard bench for uart_trx: three instances (plain, even/2-stop loopback,
// odd parity) with directed stimulus and queue-based monitors.
`timescale 1ns/1ps
module tb_uart_trx;

  localparam int BD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic       rx0 = 1'b1, tx0, tx_valid0 = 1'b0, tx_ready0, rx_valid0, rx_perr0, rx_ferr0;
  logic [7:0] tx_data0 = 8'h00, rx_data0;
  logic       tx_e, tx_valid_e = 1'b0, tx_ready_e, rx_valid_e, rx_perr_e, rx_ferr_e;
  logic [7:0] tx_data_e = 8'h00, rx_data_e;
  logic       rx_o = 1'b1, tx_o, tx_valid_o = 1'b0, tx_ready_o, rx_valid_o, rx_perr_o, rx_ferr_o;
  logic [7:0] tx_data_o = 8'h00, rx_data_o;

  uart_trx #(.BAUD_DIVIDER(BD)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .tx(tx0), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_parity_err(rx_perr0), .rx_frame_err(rx_ferr0));

  uart_trx #(.BAUD_DIVIDER(BD), .PARITY(2), .STOP_BITS(2)) u_dut_e (
    .clk(clk), .rst_n(rst_n), .rx(tx_e), .tx(tx_e), .tx_data(tx_data_e), .tx_valid(tx_valid_e),
    .tx_ready(tx_ready_e), .rx_data(rx_data_e), .rx_valid(rx_valid_e),
    .rx_parity_err(rx_perr_e), .rx_frame_err(rx_ferr_e));

  uart_trx #(.BAUD_DIVIDER(BD), .PARITY(1)) u_dut_o (
    .clk(clk), .rst_n(rst_n), .rx(rx_o), .tx(tx_o), .tx_data(tx_data_o), .tx_valid(tx_valid_o),
    .tx_ready(tx_ready_o), .rx_data(rx_data_o), .rx_valid(rx_valid_o),
    .rx_parity_err(rx_perr_o), .rx_frame_err(rx_ferr_o));

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic flag(input string name);
    n_total++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask

  // Scoreboard queues: rx entries are {frame_err, parity_err, data[7:0]}.
  logic [9:0] q_rx0[$], q_rx_e[$], q_rx_o[$];
  logic       q_tx[$];
  int         q_busy[$];
  int         n_strobe0 = 0;
  int         cyc = 0;
  int         last_e = -1;
  int         busy_cnt = 0;
  bit         tx_chk_en = 1'b1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && rx_valid0) begin
      n_strobe0++;
      if (q_rx0.size() == 0) flag("rx0_strobe");
      else check("rx0_frame", int'({rx_ferr0, rx_perr0, rx_data0}), int'(q_rx0.pop_front()));
    end
    if (rst_n && rx_valid_e) begin
      if (last_e >= 0) check("rx_e_gap", cyc - last_e, 49);
      last_e = cyc;
      if (q_rx_e.size() == 0) flag("rx_e_strobe");
      else check("rx_e_frame", int'({rx_ferr_e, rx_perr_e, rx_data_e}), int'(q_rx_e.pop_front()));
    end
    if (rst_n && rx_valid_o) begin
      if (q_rx_o.size() == 0) flag("rx_o_strobe");
      else check("rx_o_frame", int'({rx_ferr_o, rx_perr_o, rx_data_o}), int'(q_rx_o.pop_front()));
    end
    if (rst_n && tx_chk_en) begin
      if (!tx_ready0) begin
        busy_cnt++;
        if (q_tx.size() == 0) flag("tx0_extra_busy");
        else check("tx0_level", int'(tx0), int'(q_tx.pop_front()));
      end else if (busy_cnt != 0) begin
        if (q_busy.size() == 0) flag("tx0_busy");
        else check("tx0_busy_len", busy_cnt, q_busy.pop_front());
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_ready(input int which);
    int n = 0;
    while (((which == 0) ? tx_ready0 : tx_ready_e) == 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("tx_ready_timeout", n, 0);
  endtask

  task automatic drive_bit(input int which, input logic lvl, input int clks);
    if (which == 0) rx0 = lvl;
    else rx_o = lvl;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input bit use_par,
                            input logic par, input logic stop);
    drive_bit(which, 1'b0, BD);
    for (int i = 0; i < 8; i++) drive_bit(which, data[i], BD);
    if (use_par) drive_bit(which, par, BD);
    drive_bit(which, stop, BD);
    drive_bit(which, 1'b1, 2 * BD);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] seq_a5;
    logic [7:0] e_data[3];
    seq_a5    = 10'b1101001010;  // tx levels for 0xA5, index 0 first
    e_data[0] = 8'h00;
    e_data[1] = 8'hFF;
    e_data[2] = 8'h3C;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx0), 1);
    check("rst_tx_ready", int'(tx_ready0), 1);
    check("rst_rx_valid", int'(rx_valid0), 0);
    check("rst_rx_data", int'(rx_data0), 0);
    check("rst_perr", int'(rx_perr0), 0);
    check("rst_ferr", int'(rx_ferr0), 0);
    check("rst_tx_o", int'(tx_o), 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xA5 on the plain instance, with ignored input activity while busy
    for (int i = 0; i < 10; i++) repeat (BD) q_tx.push_back(seq_a5[i]);
    q_busy.push_back(40);
    tx_data0 = 8'hA5; tx_valid0 = 1'b1;
    @(negedge clk);
    tx_valid0 = 1'b0; tx_data0 = 8'h00;
    repeat (10) @(negedge clk);
    tx_valid0 = 1'b1;
    @(negedge clk);
    tx_valid0 = 1'b0;
    @(negedge clk);
    wait_ready(0);
    repeat (3) @(negedge clk);
    check("tx0_idle_high", int'(tx0), 1);

    // Back-to-back loopback frames, even parity, two stop bits
    for (int i = 0; i < 3; i++) begin
      q_rx_e.push_back({2'b00, e_data[i]});
      tx_data_e = e_data[i]; tx_valid_e = 1'b1;
      wait_ready(1);
      @(negedge clk);
    end
    tx_valid_e = 1'b0;
    repeat (80) @(negedge clk);

    // Odd parity receive: wrong parity, correct parity, framing error
    q_rx_o.push_back({1'b0, 1'b1, 8'h07});
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    q_rx_o.push_back({1'b0, 1'b0, 8'h07});
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    q_rx_o.push_back({1'b1, 1'b0, 8'h80});
    send_frame(1, 8'h80, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    // One-clock glitch is a false start
    drive_bit(0, 1'b0, 1);
    drive_bit(0, 1'b1, 20);
    check("glitch_no_strobe", n_strobe0, 0);

    // Break: line low for 20 bit times gives a single framing-error strobe
    q_rx0.push_back({1'b1, 1'b0, 8'h00});
    drive_bit(0, 1'b0, 20 * BD);
    check("break_strobes", n_strobe0, 1);
    check("break_rx_data_hold", int'(rx_data0), 0);
    check("break_ferr_hold", int'(rx_ferr0), 1);
    drive_bit(0, 1'b1, 2 * BD);
    q_rx0.push_back({2'b00, 8'h5A});
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    check("rearm_strobes", n_strobe0, 2);

    // Reset during Tx data bit 3 (0x33 bit 3 is 0) and mid Rx frame
    tx_chk_en = 1'b0;
    tx_data0 = 8'h33; tx_valid0 = 1'b1;
    @(negedge clk);
    tx_valid0 = 1'b0; rx_o = 1'b0;
    repeat (18) @(negedge clk);
    #2;
    check("tx_bit3_low", int'(tx0), 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", int'(tx0), 1);
    check("rst_mid_tx_ready", int'(tx_ready0), 1);
    check("rst_mid_rx_data", int'(rx_data0), 0);
    check("rst_mid_rx_data_o", int'(rx_data_o), 0);
    rx_o = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_tx", int'(tx0), 1);

    check("q_rx0_empty", q_rx0.size(), 0);
    check("q_rx_e_empty", q_rx_e.size(), 0);
    check("q_rx_o_empty", q_rx_o.size(), 0);
    check("q_tx_empty", q_tx.size(), 0);
    check("q_busy_empty", q_busy.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
